previn_serializer: RTL and testbench

- Multi-channel, parametrised generator of the PREVIN serial stream.
- Latches one WIDTH-bit code per channel on a load strobe and shifts it out MSB-first, one bit per bit_tick, after LEAD_BITS leading zeros.
- Fully synchronous to clk. The upstream front-end converts the fdata_G falling edge into a single-cycle bit_tick.
- Adds repeat mode, a one-deep pending load, and busy/done status for the PC interface.

---
 rtl/previn_pkg.sv | 13 +
 rtl/previn_shreg.sv | 41 ++++
 rtl/previn_serializer.sv | 111 +++++++++++
 tb/tb_previn_serializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/previn_pkg.sv
// Shared state encoding and idle line level for the PREVIN serializer.
// Pure declarations: no timing and no flow control.
package previn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic PREVIN_IDLE_LVL = 1'b0;

endpackage

// File: rtl/previn_shreg.sv
// Per-channel shadow and pending code registers with a bit-select output mux.
// previn follows the registered shadow in the same cycle; loads are strobe-driven with no backpressure.
module previn_shreg
    import previn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] code,
    input  logic             ld_code,
    input  logic             ld_pend,
    input  logic             ld_from_pend,
    input  logic             active,
    input  logic             lead,
    input  logic [IDX_W-1:0] bit_idx,
    output logic             previn
);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] pend_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            pend_code <= '0;
        end else begin
            // A fresh code on the input beats the queued one at a frame boundary.
            if (ld_code)
                shadow <= code;
            else if (ld_from_pend)
                shadow <= pend_code;
            if (ld_pend)
                pend_code <= code;
        end
    end

    assign previn = (active && !lead) ? shadow[bit_idx] : PREVIN_IDLE_LVL;

endmodule

// File: rtl/previn_serializer.sv
// Multi-channel PREVIN serializer: LEAD_BITS zeros then a WIDTH-bit code, MSB first, one bit per bit_tick.
// First bit visible the cycle after trig; trig while busy queues one code (last wins); no backpressure.
module previn_serializer
    import previn_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_CH    = 1,
    parameter int LEAD_BITS = 1,
    parameter int CNT_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bit_tick,
    input  logic                    trig,
    input  logic [NUM_CH*WIDTH-1:0] code,
    input  logic                    repeat_en,
    output logic                    busy,
    output logic                    pending,
    output logic                    done,
    output logic [NUM_CH-1:0]       previn
);

    localparam int               FRAME_LEN  = LEAD_BITS + WIDTH;
    localparam int               IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'((LEAD_BITS > 0) ? LEAD_BITS - 1 : 0);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam state_t           START_ST   = (LEAD_BITS > 0) ? LEAD : DATA;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             frame_end;
    logic             ld_code;
    logic             ld_pend;
    logic             ld_from_pend;
    logic [IDX_W-1:0] bit_idx;

    assign frame_end    = (state == DATA) && bit_tick && (cnt == FRAME_LAST);
    assign ld_code      = trig && ((state == IDLE) || frame_end);
    assign ld_pend      = trig && (state != IDLE) && !frame_end;
    assign ld_from_pend = frame_end && pending && !trig;
    // cnt counts frame bits including the lead; the code index runs downward from WIDTH-1.
    assign bit_idx      = IDX_W'(WIDTH - 1 + LEAD_BITS - 32'(cnt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            pending <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        state <= START_ST;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                LEAD: begin
                    if (trig)
                        pending <= 1'b1;
                    if (bit_tick) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LEAD_LAST)
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (frame_end) begin
                        done    <= 1'b1;
                        pending <= 1'b0;
                        cnt     <= '0;
                        if (trig || pending || repeat_en) begin
                            state <= START_ST;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        if (trig)
                            pending <= 1'b1;
                        if (bit_tick)
                            cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        previn_shreg #(
            .WIDTH (WIDTH),
            .IDX_W (IDX_W)
        ) u_shreg (
            .clk          (clk),
            .rst_n        (rst_n),
            .code         (code[c*WIDTH +: WIDTH]),
            .ld_code      (ld_code),
            .ld_pend      (ld_pend),
            .ld_from_pend (ld_from_pend),
            .active       (state != IDLE),
            .lead         (state == LEAD),
            .bit_idx      (bit_idx),
            .previn       (previn[c])
        );
    end

endmodule

// File: tb/tb_previn_serializer.sv
// Directed bench for previn_serializer: default configuration plus a 2-channel, 4-bit, no-lead instance.
module tb_previn_serializer;

    logic       clk;
    logic       rst_n;
    logic       bit_tick, trig, repeat_en;
    logic [7:0] code;
    logic       busy, pending, done;
    logic [0:0] previn;

    logic       bit_tick2, trig2, repeat2;
    logic [7:0] code2;
    logic       busy2, pending2, done2;
    logic [1:0] previn2;

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] frame;

    previn_serializer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_tick  (bit_tick),
        .trig      (trig),
        .code      (code),
        .repeat_en (repeat_en),
        .busy      (busy),
        .pending   (pending),
        .done      (done),
        .previn    (previn)
    );

    previn_serializer #(.WIDTH(4), .NUM_CH(2), .LEAD_BITS(0), .CNT_W(5)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_tick  (bit_tick2),
        .trig      (trig2),
        .code      (code2),
        .repeat_en (repeat2),
        .busy      (busy2),
        .pending   (pending2),
        .done      (done2),
        .previn    (previn2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Three idle cycles then a one-cycle bit_tick; returns just after the tick's edge.
    task automatic tick();
        step(); step(); step();
        bit_tick = 1'b1;
        step();
        bit_tick = 1'b0;
    endtask

    task automatic tick2();
        step(); step(); step();
        bit_tick2 = 1'b1;
        step();
        bit_tick2 = 1'b0;
    endtask

    task automatic load(input logic [7:0] c);
        code = c;
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; bit_tick = 1'b0; trig = 1'b0; repeat_en = 1'b0; code = '0;
        bit_tick2 = 1'b0; trig2 = 1'b0; repeat2 = 1'b0; code2 = '0;
        step(); step();
        check("rst_previn", previn, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        // 1: A5 with one lead zero
        frame = {1'b0, 8'hA5};
        load(8'hA5);
        check("t1_busy", busy, 1);
        check("t1_bit0", previn, frame[8]);
        for (int b = 1; b <= 8; b++) begin
            tick();
            check($sformatf("t1_bit%0d", b), previn, frame[8-b]);
            check($sformatf("t1_nodone%0d", b), done, 0);
        end
        tick();
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_previn_end", previn, 0);
        step();
        check("t1_done_once", done, 0);

        // 2: two channels in parallel, no lead bits
        code2 = {4'h3, 4'hC};
        trig2 = 1'b1;
        step();
        trig2 = 1'b0;
        check("t2_bit0", previn2, 2'b01);
        tick2(); check("t2_bit1", previn2, 2'b01);
        tick2(); check("t2_bit2", previn2, 2'b10);
        tick2(); check("t2_bit3", previn2, 2'b10);
        tick2();
        check("t2_done", done2, 1);
        check("t2_idle", previn2, 2'b00);
        check("t2_busy", busy2, 0);

        // 3: repeat mode, three frames, drop repeat_en mid third frame
        frame = {1'b0, 8'h81};
        repeat_en = 1'b1;
        load(8'h81);
        for (int f = 0; f < 3; f++) begin
            check($sformatf("t3_f%0d_bit0", f), previn, frame[8]);
            for (int b = 1; b <= 8; b++) begin
                tick();
                check($sformatf("t3_f%0d_bit%0d", f, b), previn, frame[8-b]);
                if (f == 2 && b == 4) repeat_en = 1'b0;
            end
            tick();
            check($sformatf("t3_f%0d_done", f), done, 1);
            check($sformatf("t3_f%0d_busy", f), busy, (f < 2) ? 1 : 0);
        end
        check("t3_idle_previn", previn, 0);

        // 4: two queued loads during a frame, last one wins
        load(8'hF0);
        tick(); tick();
        load(8'h0F);
        check("t4_pend1", pending, 1);
        tick();
        load(8'h3C);
        check("t4_pend2", pending, 1);
        check("t4_cur_bit3", previn, 1);
        repeat (5) tick();
        tick();
        check("t4_done", done, 1);
        check("t4_busy", busy, 1);
        check("t4_pend_clr", pending, 0);
        check("t4_lead", previn, 0);
        frame = {1'b0, 8'h3C};
        for (int b = 1; b <= 8; b++) begin
            tick();
            check($sformatf("t4_bit%0d", b), previn, frame[8-b]);
        end
        tick();
        check("t4_end_busy", busy, 0);

        // 5a: trig coincident with bit_tick in IDLE, tick must be ignored
        code = 8'h80; trig = 1'b1; bit_tick = 1'b1;
        step();
        trig = 1'b0; bit_tick = 1'b0;
        check("t5_lead", previn, 0);
        tick();
        check("t5_msb", previn, 1);
        repeat (7) tick();
        check("t5_busy_t8", busy, 1);
        check("t5_nodone_t8", done, 0);
        tick();
        check("t5_busy_t9", busy, 0);
        check("t5_done_t9", done, 1);

        // 5b: trig on the frame-ending tick restarts with no IDLE cycle
        load(8'h55);
        repeat (8) tick();
        step(); step(); step();
        code = 8'hC3; trig = 1'b1; bit_tick = 1'b1;
        step();
        trig = 1'b0; bit_tick = 1'b0;
        check("t5b_busy", busy, 1);
        check("t5b_done", done, 1);
        check("t5b_pend", pending, 0);
        check("t5b_lead", previn, 0);
        tick(); check("t5b_bit1", previn, 1);
        tick(); check("t5b_bit2", previn, 1);
        tick(); check("t5b_bit3", previn, 0);
        repeat (6) tick();
        check("t5b_end", busy, 0);

        // 6: asynchronous reset mid-frame with a queued load
        load(8'hFF);
        repeat (4) tick();
        load(8'h77);
        check("t6_pend", pending, 1);
        check("t6_prev_hi", previn, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_previn", previn, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_pending", pending, 0);
        check("t6_rst_done", done, 0);
        step();
        rst_n = 1'b1;
        step();
        tick();
        check("t6_post_previn", previn, 0);
        check("t6_post_busy", busy, 0);
        tick();
        check("t6_post_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
